// File: rtl/hack_pkg.sv
// Shared definitions for the Hack-style CPU pipeline.
//   - Bit positions of the C-instruction fields.
//   - Indices of the {A,D,M} destination bits.
//   - The default NOP comp code (ALU constant 0).
//   - ctrl_t: the decoded-control word passed from decode to execute.
package hack_pkg;

    // C-instruction field positions
    localparam int COMP_LSB = 6;
    localparam int DEST_LSB = 3;
    localparam int JUMP_LSB = 0;
    localparam int A_BIT    = 12;

    // dest bit indices inside the 3-bit dest field
    localparam int DEST_A = 2;
    localparam int DEST_D = 1;
    localparam int DEST_M = 0;

    // ALU comp code that produces the constant 0
    localparam logic [5:0] NOP_COMP_DEF = 6'b101010;

    // Decoded control word shared with the execute stage
    typedef struct packed {
        logic       is_c;     // 1 = C-instruction
        logic       a_bit;    // ALU y operand: 0 = A, 1 = M
        logic [5:0] comp;     // ALU comp field
        logic [2:0] dest;     // {A,D,M} write enables
        logic [2:0] jump;     // jump condition
        logic [1:0] ext;      // extension opcode
        logic       load_a;   // A-register load enable
        logic       a_src;    // 0 = immediate, 1 = ALU result
        logic       illegal;  // beat is illegal, fields forced to NOP
    } ctrl_t;

endpackage

// File: rtl/hack_decode_comb.sv
// Pure combinational Hack instruction decoder.
// Ports:
//   i_instr  in  IW      raw instruction (MSB: 0 = A, 1 = C)
//   o_ctrl   out ctrl_t  decoded control fields
//   o_imm    out IW      zero-extended i_instr[IW-2:0]
module hack_decode_comb
    import hack_pkg::*;
#(
    parameter int         IW       = 16,
    parameter int         EXT_EN   = 0,
    parameter logic [5:0] NOP_COMP = NOP_COMP_DEF
) (
    input  logic [IW-1:0] i_instr,
    output ctrl_t         o_ctrl,
    output logic [IW-1:0] o_imm
);

    logic [1:0] w_op;

    assign w_op  = i_instr[IW-2:IW-3];
    assign o_imm = {1'b0, i_instr[IW-2:0]};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the if-chain can leave it unassigned and infer a latch.
        o_ctrl         = '0;
        o_ctrl.comp    = NOP_COMP;
        o_ctrl.load_a  = 1'b1;   // A-instruction: load immediate into A
        o_ctrl.a_src   = 1'b0;

        if (i_instr[IW-1]) begin
            o_ctrl.is_c   = 1'b1;
            o_ctrl.a_bit  = i_instr[A_BIT];
            o_ctrl.comp   = i_instr[COMP_LSB +: 6];
            o_ctrl.dest   = i_instr[DEST_LSB +: 3];
            o_ctrl.jump   = i_instr[JUMP_LSB +: 3];
            o_ctrl.load_a = i_instr[DEST_LSB + DEST_A];
            o_ctrl.a_src  = 1'b1;

            if (EXT_EN != 0) begin
                o_ctrl.ext = w_op;
            end else if (w_op != 2'b11) begin
                // Without extensions the two spare bits must be 11; anything
                // else becomes a NOP that writes nothing and never jumps.
                o_ctrl.illegal = 1'b1;
                o_ctrl.comp    = NOP_COMP;
                o_ctrl.dest    = 3'b000;
                o_ctrl.jump    = 3'b000;
                o_ctrl.load_a  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/hack_decode_stage.sv
// Registered Hack instruction-decode stage with a 2-entry skid buffer.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   flush                 synchronous flush: drops everything in flight
//   in_valid/in_ready     fetch-side handshake; in_ready = ~skid_valid
//   in_instr [IW]         instruction from fetch
//   out_valid/out_ready   execute-side handshake
//   out_is_c .. out_illegal  decoded fields of the beat in the out stage
//   out_imm [IW]          zero-extended immediate, driven for every beat
//   ill_count [CNT_W]     saturating count of accepted illegal beats
module hack_decode_stage
    import hack_pkg::*;
#(
    parameter int         IW       = 16,
    parameter int         EXT_EN   = 0,
    parameter logic [5:0] NOP_COMP = NOP_COMP_DEF,
    parameter int         CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IW-1:0]    in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_is_c,
    output logic             out_a_bit,
    output logic [5:0]       out_comp,
    output logic [2:0]       out_dest,
    output logic [2:0]       out_jump,
    output logic [1:0]       out_ext,
    output logic             out_load_a,
    output logic             out_a_src,
    output logic [IW-1:0]    out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] ill_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_t          w_dec;
    logic [IW-1:0]  w_imm;
    logic           w_accept;
    logic           w_out_free;

    ctrl_t          r_out_ctrl;
    logic [IW-1:0]  r_out_imm;
    logic           r_out_valid;
    ctrl_t          r_skid_ctrl;
    logic [IW-1:0]  r_skid_imm;
    logic           r_skid_valid;
    logic [CNT_W-1:0] r_ill_count;

    hack_decode_comb #(
        .IW       (IW),
        .EXT_EN   (EXT_EN),
        .NOP_COMP (NOP_COMP)
    ) u_decode (
        .i_instr (in_instr),
        .o_ctrl  (w_dec),
        .o_imm   (w_imm)
    );

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready   = ~r_skid_valid;
    assign w_accept   = in_valid & ~r_skid_valid;
    // The out stage can take a new beat when empty or being consumed.
    assign w_out_free = ~r_out_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: payload registers are reset along with the valid bits so
            // every out_* field reads 0 after reset, not only out_valid.
            r_out_valid  <= 1'b0;
            r_out_ctrl   <= '0;
            r_out_imm    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_imm   <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                // Skid holds the older beat; in_ready is low so no accept.
                // NOTE: non-blocking assignments let this edge read the old
                // skid contents while clearing skid_valid in the same cycle.
                r_out_ctrl   <= r_skid_ctrl;
                r_out_imm    <= r_skid_imm;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_ctrl  <= w_dec;
                r_out_imm   <= w_imm;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            // Out stage full and stalled: park the beat in the skid entry.
            r_skid_ctrl  <= w_dec;
            r_skid_imm   <= w_imm;
            r_skid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ill_count <= '0;
        end else if (!flush && w_accept && w_dec.illegal && (r_ill_count != CNT_MAX)) begin
            r_ill_count <= r_ill_count + 1'b1;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_is_c    = r_out_ctrl.is_c;
    assign out_a_bit   = r_out_ctrl.a_bit;
    assign out_comp    = r_out_ctrl.comp;
    assign out_dest    = r_out_ctrl.dest;
    assign out_jump    = r_out_ctrl.jump;
    assign out_ext     = r_out_ctrl.ext;
    assign out_load_a  = r_out_ctrl.load_a;
    assign out_a_src   = r_out_ctrl.a_src;
    assign out_imm     = r_out_imm;
    assign out_illegal = r_out_ctrl.illegal;
    assign ill_count   = r_ill_count;

endmodule

// File: tb/tb_hack_decode_stage.sv
// Scoreboard bench for hack_decode_stage (IW=16, EXT_EN=0, CNT_W=2).
// Stimulus pushes the hand-computed expected beat when its input handshake
// happens; an independent monitor compares the out stage against the queue
// head on every falling edge and pops it when execute accepts the beat.
module tb_hack_decode_stage;

    typedef struct packed {
        logic        is_c;
        logic        a_bit;
        logic [5:0]  comp;
        logic [2:0]  dest;
        logic [2:0]  jump;
        logic [1:0]  ext;
        logic        load_a;
        logic        a_src;
        logic        illegal;
        logic [15:0] imm;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic        out_is_c;
    logic        out_a_bit;
    logic [5:0]  out_comp;
    logic [2:0]  out_dest;
    logic [2:0]  out_jump;
    logic [1:0]  out_ext;
    logic        out_load_a;
    logic        out_a_src;
    logic [15:0] out_imm;
    logic        out_illegal;
    logic [1:0]  ill_count;

    int    total = 0;
    int    bad   = 0;
    beat_t exp_q[$];
    beat_t vec[10];
    logic [15:0] vin[10];

    always #5 clk = ~clk;

    hack_decode_stage #(
        .IW       (16),
        .EXT_EN   (0),
        .NOP_COMP (6'b101010),
        .CNT_W    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_is_c    (out_is_c),
        .out_a_bit   (out_a_bit),
        .out_comp    (out_comp),
        .out_dest    (out_dest),
        .out_jump    (out_jump),
        .out_ext     (out_ext),
        .out_load_a  (out_load_a),
        .out_a_src   (out_a_src),
        .out_imm     (out_imm),
        .out_illegal (out_illegal),
        .ill_count   (ill_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input logic is_c, input logic a_bit, input logic [5:0] comp,
                                 input logic [2:0] dest, input logic [2:0] jump,
                                 input logic load_a, input logic a_src, input logic ill,
                                 input logic [15:0] imm);
        beat_t b;
        b.is_c    = is_c;
        b.a_bit   = a_bit;
        b.comp    = comp;
        b.dest    = dest;
        b.jump    = jump;
        b.ext     = 2'b00;
        b.load_a  = load_a;
        b.a_src   = a_src;
        b.illegal = ill;
        b.imm     = imm;
        return b;
    endfunction

    function automatic beat_t observed();
        beat_t b;
        b.is_c    = out_is_c;
        b.a_bit   = out_a_bit;
        b.comp    = out_comp;
        b.dest    = out_dest;
        b.jump    = out_jump;
        b.ext     = out_ext;
        b.load_a  = out_load_a;
        b.a_src   = out_a_src;
        b.illegal = out_illegal;
        b.imm     = out_imm;
        return b;
    endfunction

    // Monitor: every presented beat must equal the queue head, including
    // each stalled cycle, which also proves the fields are held stable.
    always @(negedge clk) begin
        if (rst_n && !flush && out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_beat: got %h, want no beat (t=%0t)", observed(), $time);
            end else begin
                check("beat", 64'(observed()), 64'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic send(input int idx);
        bit done = 0;
        in_valid = 1'b1;
        in_instr = vin[idx];
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                if (!flush) exp_q.push_back(vec[idx]);
                done = 1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 for 100 cycles, want 1 (vec %0d)", idx);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        check("idle_out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Hand-decoded vectors (EXT_EN=0, NOP comp = 101010).
        vin[0] = 16'h1234; vec[0] = mk(0, 0, 6'b101010, 3'b000, 3'b000, 1, 0, 0, 16'h1234);
        vin[1] = 16'hFC10; vec[1] = mk(1, 1, 6'b110000, 3'b010, 3'b000, 0, 1, 0, 16'h7C10);
        vin[2] = 16'hEABB; vec[2] = mk(1, 0, 6'b101010, 3'b111, 3'b011, 1, 1, 0, 16'h6ABB);
        vin[3] = 16'h7FFF; vec[3] = mk(0, 0, 6'b101010, 3'b000, 3'b000, 1, 0, 0, 16'h7FFF);
        vin[4] = 16'h0000; vec[4] = mk(0, 0, 6'b101010, 3'b000, 3'b000, 1, 0, 0, 16'h0000);
        vin[5] = 16'hF1C8; vec[5] = mk(1, 1, 6'b000111, 3'b001, 3'b000, 0, 1, 0, 16'h71C8);
        vin[6] = 16'h8000; vec[6] = mk(1, 0, 6'b101010, 3'b000, 3'b000, 0, 1, 1, 16'h0000);
        vin[7] = 16'hA000; vec[7] = mk(1, 0, 6'b101010, 3'b000, 3'b000, 0, 1, 1, 16'h2000);
        vin[8] = 16'hC000; vec[8] = mk(1, 0, 6'b101010, 3'b000, 3'b000, 0, 1, 1, 16'h4000);
        vin[9] = 16'h8FFF; vec[9] = mk(1, 0, 6'b101010, 3'b000, 3'b000, 0, 1, 1, 16'h0FFF);

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 16'h0000;
        out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_ill_count", 64'(ill_count), 64'd0);
        check("rst_fields",    64'(observed()), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic decode, single beat then back-to-back with out_ready=1
        out_ready = 1'b1;
        send(0);
        check("latency_out_valid", 64'(out_valid), 64'd1);
        for (int i = 1; i < 6; i++) send(i);
        drain();

        // Back-pressure: four back-to-back beats, execute stalled from the start
        out_ready = 1'b0;
        fork
            begin
                send(2);
                send(3);
                check("bp_in_ready_low", 64'(in_ready), 64'd0);
                send(4);
                send(5);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Flush with out stage and skid full and an illegal beat on the input
        out_ready = 1'b0;
        send(0);
        send(1);
        check("fl_skid_full", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_instr = vin[6];
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_in_ready",  64'(in_ready),  64'd1);
        check("fl_ill_count", 64'(ill_count), 64'd0);
        // Flush while an illegal beat is actually handshaken: dropped, not counted
        in_valid = 1'b1;
        in_instr = vin[7];
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl2_out_valid", 64'(out_valid), 64'd0);
        check("fl2_ill_count", 64'(ill_count), 64'd0);
        out_ready = 1'b1;
        send(2);
        drain();

        // Illegal beats: counter 1, 2, 3 then saturates at 3
        for (int i = 0; i < 5; i++) begin
            send(6 + (i % 4));
            check("ill_count", 64'(ill_count), 64'((i < 3) ? i + 1 : 3));
        end
        drain();

        // Asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        send(0);
        send(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 64'(out_valid), 64'd0);
        check("ar_in_ready",  64'(in_ready),  64'd1);
        check("ar_ill_count", 64'(ill_count), 64'd0);
        check("ar_fields",    64'(observed()), 64'd0);
        exp_q.delete();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(1);
        check("ar_post_valid", 64'(out_valid), 64'd1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
